// File: rtl/fm_error_monitor_if.sv
// Bus bundle between a product source and fm_error_monitor: sample input
// handshake plus report output handshake.
interface fm_error_monitor_if #(
    parameter int ERR_W = 32
);
    // Both channels: a transfer happens on a rising edge where valid & ready
    // are both high; valid holds with stable data until that edge.
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       approx;
    logic [31:0]       exact;
    logic              rpt_valid;
    logic              rpt_ready;
    logic [ERR_W-1:0]  rpt_err_sum;
    logic [22:0]       rpt_err_max;
    logic [15:0]       rpt_exact_cnt;
    logic [15:0]       rpt_mismatch_cnt;

    modport master (
        output in_valid, approx, exact, rpt_ready,
        input  in_ready, rpt_valid, rpt_err_sum, rpt_err_max,
               rpt_exact_cnt, rpt_mismatch_cnt
    );

    modport slave (
        input  in_valid, approx, exact, rpt_ready,
        output in_ready, rpt_valid, rpt_err_sum, rpt_err_max,
               rpt_exact_cnt, rpt_mismatch_cnt
    );
endinterface

// File: rtl/fm_error_monitor.sv
// Accuracy monitor for the approximate FP multiplier: classifies each
// approx/exact pair, accumulates a WINDOW-sample report, hands it off.
module fm_error_monitor #(
    parameter int WINDOW = 16,
    parameter int ERR_W  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    fm_error_monitor_if.slave    bus,
    output logic [1:0]           dbg_state
);
    typedef enum logic [1:0] {
        ST_ACC   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_RPT   = 2'd2
    } state_t;

    // Sum is formed one bit wider than the larger operand so saturation can
    // be detected even when a single error exceeds the accumulator width.
    localparam int             SW      = ((ERR_W > 23) ? ERR_W : 23) + 1;
    localparam logic [SW-1:0]  SUM_MAX = SW'({ERR_W{1'b1}});
    localparam logic [15:0]    LAST    = 16'(WINDOW - 1);

    state_t state, state_next;

    logic        accept, last_accept, rpt_take;
    logic [15:0] cnt;

    logic        s1_valid, s1_exact, s1_mis;
    logic [22:0] s1_err;
    logic        s2_valid;

    logic [ERR_W-1:0] acc_sum;
    logic [22:0]      acc_max;
    logic [15:0]      acc_exact;
    logic [15:0]      acc_mis;

    logic        special, mismatch;
    logic [7:0]  a_exp, e_exp;
    logic [22:0] a_man, e_man, diff, err1;

    logic [SW-1:0]    sum_ext;
    logic [ERR_W-1:0] sum_next;

    assign bus.in_ready = (state == ST_ACC);
    assign accept       = bus.in_valid & bus.in_ready;
    assign last_accept  = accept && (cnt == LAST);
    assign rpt_take     = (state == ST_RPT) & bus.rpt_ready;
    assign dbg_state    = state;

    // Stage 1 classification
    always_comb begin
        a_exp    = bus.approx[30:23];
        e_exp    = bus.exact[30:23];
        a_man    = bus.approx[22:0];
        e_man    = bus.exact[22:0];
        special  = (a_exp == 8'h00) || (a_exp == 8'hFF) ||
                   (e_exp == 8'h00) || (e_exp == 8'hFF);
        mismatch = special || (bus.approx[31] != bus.exact[31]) || (a_exp != e_exp);
        diff     = (a_man >= e_man) ? (a_man - e_man) : (e_man - a_man);
        err1     = mismatch ? 23'd0 : diff;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_err   <= '0;
            s1_exact <= 1'b0;
            s1_mis   <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_err   <= err1;
                s1_exact <= (bus.approx == bus.exact);
                s1_mis   <= mismatch;
            end
        end
    end

    always_comb begin
        sum_ext  = SW'(acc_sum) + SW'(s1_err);
        sum_next = (sum_ext > SUM_MAX) ? ERR_W'(SUM_MAX) : ERR_W'(sum_ext);
    end

    // Stage 2 accumulation; the report handshake clears everything
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid  <= 1'b0;
            acc_sum   <= '0;
            acc_max   <= '0;
            acc_exact <= '0;
            acc_mis   <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (rpt_take) begin
                acc_sum   <= '0;
                acc_max   <= '0;
                acc_exact <= '0;
                acc_mis   <= '0;
            end else if (s1_valid) begin
                acc_sum   <= sum_next;
                acc_max   <= (s1_err > acc_max) ? s1_err : acc_max;
                acc_exact <= acc_exact + 16'(s1_exact);
                acc_mis   <= acc_mis + 16'(s1_mis);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (rpt_take) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= last_accept ? 16'd0 : cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_ACC;
        else     state <= state_next;
    end

    // DRAIN holds until both pipeline stages are empty, which places the
    // report three edges after the window's final accept.
    always_comb begin
        state_next = state;
        case (state)
            ST_ACC:   if (last_accept)             state_next = ST_DRAIN;
            ST_DRAIN: if (!s1_valid && !s2_valid)  state_next = ST_RPT;
            ST_RPT:   if (bus.rpt_ready)           state_next = ST_ACC;
            default:                               state_next = ST_ACC;
        endcase
    end

    always_comb begin
        bus.rpt_valid        = (state == ST_RPT);
        bus.rpt_err_sum      = bus.rpt_valid ? acc_sum   : '0;
        bus.rpt_err_max      = bus.rpt_valid ? acc_max   : '0;
        bus.rpt_exact_cnt    = bus.rpt_valid ? acc_exact : '0;
        bus.rpt_mismatch_cnt = bus.rpt_valid ? acc_mis   : '0;
    end
endmodule

// File: tb/tb_fm_error_monitor.sv
// Directed bench: two monitors (ERR_W=32 and ERR_W=8, both WINDOW=4) see
// identical stimulus; each report is checked against hand-computed values.
module tb_fm_error_monitor;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] approx, exact;
    logic        rpt_ready;
    logic [1:0]  dbg_a, dbg_b;

    int n_total = 0;
    int n_pass  = 0;

    fm_error_monitor_if #(.ERR_W(32)) a ();
    fm_error_monitor_if #(.ERR_W(8))  b ();

    assign a.in_valid  = in_valid;
    assign a.approx    = approx;
    assign a.exact     = exact;
    assign a.rpt_ready = rpt_ready;
    assign b.in_valid  = in_valid;
    assign b.approx    = approx;
    assign b.exact     = exact;
    assign b.rpt_ready = rpt_ready;

    fm_error_monitor #(.WINDOW(4), .ERR_W(32)) dut_a (.clk(clk), .rst(rst), .bus(a), .dbg_state(dbg_a));
    fm_error_monitor #(.WINDOW(4), .ERR_W(8))  dut_b (.clk(clk), .rst(rst), .bus(b), .dbg_state(dbg_b));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_total++;
        assert (got === want) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, want);
    endtask

    task automatic push(input logic [31:0] ap, input logic [31:0] ex);
        in_valid = 1'b1;
        approx   = ap;
        exact    = ex;
        tick();
    endtask

    task automatic gap();
        in_valid = 1'b0;
        tick();
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " rv_a"}, 64'(a.rpt_valid), 64'd0);
        chk({tag, " rv_b"}, 64'(b.rpt_valid), 64'd0);
        chk({tag, " rdy_a"}, 64'(a.in_ready), 64'd1);
        chk({tag, " rdy_b"}, 64'(b.in_ready), 64'd1);
        chk({tag, " sum_a"}, 64'(a.rpt_err_sum), 64'd0);
        chk({tag, " sum_b"}, 64'(b.rpt_err_sum), 64'd0);
        chk({tag, " max_a"}, 64'(a.rpt_err_max), 64'd0);
        chk({tag, " ec_a"}, 64'(a.rpt_exact_cnt), 64'd0);
        chk({tag, " mc_a"}, 64'(a.rpt_mismatch_cnt), 64'd0);
        chk({tag, " st_a"}, 64'(dbg_a), 64'd0);
    endtask

    task automatic chk_fields(input string tag, input logic [63:0] sum_a, input logic [63:0] sum_b,
                              input logic [63:0] mx, input logic [63:0] ec, input logic [63:0] mc);
        chk({tag, " sum_a"}, 64'(a.rpt_err_sum), sum_a);
        chk({tag, " sum_b"}, 64'(b.rpt_err_sum), sum_b);
        chk({tag, " max_a"}, 64'(a.rpt_err_max), mx);
        chk({tag, " max_b"}, 64'(b.rpt_err_max), mx);
        chk({tag, " ec_a"}, 64'(a.rpt_exact_cnt), ec);
        chk({tag, " ec_b"}, 64'(b.rpt_exact_cnt), ec);
        chk({tag, " mc_a"}, 64'(a.rpt_mismatch_cnt), mc);
        chk({tag, " mc_b"}, 64'(b.rpt_mismatch_cnt), mc);
    endtask

    // Called one step after the window's final accepting edge.
    task automatic expect_report(input string tag, input logic [63:0] sum_a, input logic [63:0] sum_b,
                                 input logic [63:0] mx, input logic [63:0] ec, input logic [63:0] mc);
        chk({tag, " rdy drop a"}, 64'(a.in_ready), 64'd0);
        chk({tag, " rdy drop b"}, 64'(b.in_ready), 64'd0);
        chk({tag, " drain st a"}, 64'(dbg_a), 64'd1);
        chk({tag, " rv e1 a"}, 64'(a.rpt_valid), 64'd0);
        tick();
        tick();
        chk({tag, " rv e2 a"}, 64'(a.rpt_valid), 64'd0);
        chk({tag, " rv e2 b"}, 64'(b.rpt_valid), 64'd0);
        tick();
        chk({tag, " rv e3 a"}, 64'(a.rpt_valid), 64'd1);
        chk({tag, " rv e3 b"}, 64'(b.rpt_valid), 64'd1);
        chk({tag, " rpt st a"}, 64'(dbg_a), 64'd2);
        chk_fields(tag, sum_a, sum_b, mx, ec, mc);
    endtask

    task automatic take_report(input string tag);
        in_valid  = 1'b0;
        rpt_ready = 1'b1;
        tick();
        rpt_ready = 1'b0;
        chk_idle({tag, " after take"});
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        approx    = '0;
        exact     = '0;
        rpt_ready = 1'b0;
        tick();
        tick();
        chk_idle("reset");
        rst = 1'b0;
        tick();

        // 1: four bit-exact pairs, in_valid held high throughout
        for (int i = 0; i < 4; i++) push(32'h3F800000, 32'h3F800000);
        expect_report("t1", 64'd0, 64'd0, 64'd0, 64'd4, 64'd0);

        // 4: backpressure with in_valid still high and exact pairs offered
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp rv_a", 64'(a.rpt_valid), 64'd1);
            chk("bp rdy_a", 64'(a.in_ready), 64'd0);
            chk("bp rdy_b", 64'(b.in_ready), 64'd0);
            chk_fields("bp", 64'd0, 64'd0, 64'd0, 64'd4, 64'd0);
        end
        take_report("t1");

        // 2: constant mantissa error of 2 (would show exact pairs if leaked)
        for (int i = 0; i < 4; i++) push(32'h3F800003, 32'h3F800001);
        expect_report("t2", 64'd8, 64'd8, 64'd2, 64'd0, 64'd0);
        take_report("t2");

        // 3: mixed classes, with bubbles between samples
        push(32'hBF800000, 32'h3F800000);
        gap();
        push(32'h40000000, 32'h3F800000);
        gap();
        gap();
        push(32'h7F800000, 32'h7F800000);
        gap();
        push(32'h3F800010, 32'h3F800000);
        expect_report("t3", 64'd16, 64'd16, 64'd16, 64'd1, 64'd3);
        take_report("t3");

        // 5: maximal mantissa error; ERR_W=8 instance saturates
        for (int i = 0; i < 4; i++) push(32'h3F7FFFFF, 32'h3F000000);
        expect_report("t5", 64'h1FFFFFC, 64'hFF, 64'h7FFFFF, 64'd0, 64'd0);
        take_report("t5");

        // 6: reset mid-window discards partial statistics
        push(32'h3F800005, 32'h3F800000);
        push(32'h3F800005, 32'h3F800000);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk_idle("t6 rst");
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) push(32'h3F800000, 32'h3F800000);
        expect_report("t6", 64'd0, 64'd0, 64'd0, 64'd4, 64'd0);

        // Reset while a report is pending clears it immediately
        #2 rst = 1'b1;
        #1;
        chk_idle("rst in rpt");
        #1 rst = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
